// File: rtl/cmd_clk_phase_scan.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_clk_phase_scan
//  Description : Command-clock phase/fine-delay calibration. Sweeps all 32
//                {phase, fine} settings, counts SyncHit pulses per setting,
//                and selects the centre of the longest contiguous good run.
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_clk_phase_scan #(
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 1024,
    parameter int MIN_HITS      = 4,
    parameter int CNT_W         = 11
) (
    input  logic       Clk160,
    input  logic       Rst,
    input  logic       ScanStart,
    input  logic       SyncHit,
    input  logic       ManualEn,
    input  logic [4:0] ManualSetting,
    output logic       SelClkPhase,
    output logic [3:0] ClkFineDelay,
    output logic       ScanBusy,
    output logic       ScanDone,
    output logic       ScanFail,
    output logic [4:0] BestSetting,
    output logic [5:0] BestRunLen
);

    // One timer serves both SETTLE and DWELL, so size it for the longer one.
    localparam int c_TMR_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETTLE = 3'd1;
    localparam logic [2:0] c_ST_DWELL  = 3'd2;
    localparam logic [2:0] c_ST_EVAL   = 3'd3;
    localparam logic [2:0] c_ST_APPLY  = 3'd4;

    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DWELL_LAST  = c_TMR_W'(DWELL_CYCLES - 1);

    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0]   r_hits;
    logic [4:0]         r_idx;
    logic [4:0]         r_setting;
    logic [4:0]         r_restore;
    logic [4:0]         r_run_start;
    logic [5:0]         r_run_len;
    logic [4:0]         r_best_start;
    logic [5:0]         r_best_len;
    logic [4:0]         r_best_setting;
    logic [5:0]         r_best_run_len;
    logic               r_busy;
    logic               r_done;
    logic               r_fail;

    logic               w_good;
    logic               w_last;
    logic               w_close;
    logic               w_hits_sat;
    logic [5:0]         w_ext_len;
    logic [4:0]         w_ext_start;
    logic [5:0]         w_half;
    logic [4:0]         w_centre;

    // Run tracking for the EVAL cycle: the current run extended by this setting.
    always_comb begin
        w_good      = (32'(r_hits) >= 32'(MIN_HITS));
        w_last      = (r_idx == 5'd31);
        w_close     = !w_good || w_last;
        w_hits_sat  = &r_hits;
        w_ext_len   = r_run_len + {5'd0, w_good};
        w_ext_start = (w_good && (r_run_len == 6'd0)) ? r_idx : r_run_start;
        w_half      = (r_best_len - 6'd1) >> 1;
        w_centre    = r_best_start + w_half[4:0];
    end

    // Sweep sequencer with all outputs registered.
    always_ff @(posedge Clk160) begin
        if (Rst) begin
            r_state        <= c_ST_IDLE;
            r_tmr          <= '0;
            r_hits         <= '0;
            r_idx          <= 5'd0;
            r_setting      <= 5'd0;
            r_restore      <= 5'd0;
            r_run_start    <= 5'd0;
            r_run_len      <= 6'd0;
            r_best_start   <= 5'd0;
            r_best_len     <= 6'd0;
            r_best_setting <= 5'd0;
            r_best_run_len <= 6'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (ScanStart) begin
                        r_restore    <= r_setting;
                        r_setting    <= 5'd0;
                        r_idx        <= 5'd0;
                        r_tmr        <= '0;
                        r_hits       <= '0;
                        r_run_start  <= 5'd0;
                        r_run_len    <= 6'd0;
                        r_best_start <= 5'd0;
                        r_best_len   <= 6'd0;
                        r_fail       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= c_ST_SETTLE;
                    end else begin
                        r_setting <= ManualEn ? ManualSetting : r_best_setting;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_tmr == c_SETTLE_LAST) begin
                        r_tmr   <= '0;
                        r_state <= c_ST_DWELL;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                c_ST_DWELL: begin
                    if (SyncHit && !w_hits_sat) begin
                        r_hits <= r_hits + 1'b1;
                    end
                    if (r_tmr == c_DWELL_LAST) begin
                        r_tmr   <= '0;
                        r_state <= c_ST_EVAL;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                c_ST_EVAL: begin
                    r_hits <= '0;
                    if (w_close) begin
                        // Strictly greater: on a tie the earlier run wins.
                        if (w_ext_len > r_best_len) begin
                            r_best_start <= w_ext_start;
                            r_best_len   <= w_ext_len;
                        end
                        r_run_len <= 6'd0;
                    end else begin
                        r_run_start <= w_ext_start;
                        r_run_len   <= w_ext_len;
                    end
                    if (w_last) begin
                        r_state <= c_ST_APPLY;
                    end else begin
                        r_idx     <= r_idx + 5'd1;
                        r_setting <= r_idx + 5'd1;
                        r_state   <= c_ST_SETTLE;
                    end
                end
                c_ST_APPLY: begin
                    if (r_best_len != 6'd0) begin
                        r_best_setting <= w_centre;
                        r_best_run_len <= r_best_len;
                        r_setting      <= w_centre;
                        r_fail         <= 1'b0;
                    end else begin
                        r_setting <= r_restore;
                        r_fail    <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign SelClkPhase  = r_setting[4];
    assign ClkFineDelay = r_setting[3:0];
    assign ScanBusy     = r_busy;
    assign ScanDone     = r_done;
    assign ScanFail     = r_fail;
    assign BestSetting  = r_best_setting;
    assign BestRunLen   = r_best_run_len;

endmodule
`default_nettype wire

// File: doc/cmd_clk_phase_scan.md
# cmd_clk_phase_scan

Calibration controller that drives the phase-select and fine-delay inputs of the 160 MHz command-clock phase/delay stage. It sweeps all 32 settings ({phase, fine delay}), counts command-decoder sync hits at each, and selects the centre of the longest contiguous run of good settings. It sits in the end-of-column command path, clocked by the delayed Clk160 it controls, alongside the command decoder that supplies SyncHit.

## Interface
- SETTLE_CYCLES, 16, cycles per setting during which SyncHit is ignored after a setting change
- DWELL_CYCLES, 1024, cycles per setting during which SyncHit is counted
- MIN_HITS, 4, hit count at or above which a setting is good
- CNT_W, 11, hit counter width; counter saturates at 2^CNT_W-1

- Clk160  in  1  clock; all logic on its rising edge
- Rst  in  1  synchronous, active-high reset
- ScanStart  in  1  single-cycle request to start a sweep; honoured only in IDLE
- SyncHit  in  1  one-cycle pulse from the command decoder per valid sync frame
- ManualEn  in  1  in IDLE, outputs follow ManualSetting
- ManualSetting  in  5  {phase, fine[3:0]} used when ManualEn=1
- SelClkPhase  out  1  phase select to the delay stage (bit 4 of the setting)
- ClkFineDelay  out  4  fine-delay select to the delay stage (bits 3:0)
- ScanBusy  out  1  high from the cycle after the accepted ScanStart through APPLY
- ScanDone  out  1  one-cycle pulse at sweep end (success or fail)
- ScanFail  out  1  held high after a sweep that found no good setting; cleared on next accepted ScanStart
- BestSetting  out  5  selected setting from the last successful sweep
- BestRunLen  out  6  length of the winning run (0..32)

## Operation
- Setting index s[4:0]; outputs are driven as SelClkPhase=s[4], ClkFineDelay=s[3:0] while scanning.
- States: IDLE -> SETTLE -> DWELL -> EVAL -> (SETTLE with s+1 | APPLY) -> IDLE.
- IDLE: outputs = ManualSetting if ManualEn, else BestSetting. On ScanStart: s=0, hit count=0, run trackers cleared, ScanFail=0, the pre-scan output setting latched as RestoreSetting, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles; SyncHit ignored.
- DWELL: count DWELL_CYCLES cycles; each SyncHit increments the hit counter (saturating).
- EVAL (1 cycle): good = hits >= MIN_HITS. If good: extend the current run (start = s if run empty). If not good, or s=31: close the run; if its length is strictly greater than the best so far, record start/length (ties keep the earlier run). Clear the hit counter. If s=31 go to APPLY, else s=s+1 and go to SETTLE. SyncHit ignored.
- APPLY (1 cycle): if best length > 0: BestSetting = start + (len-1)>>1 (floor), BestRunLen = len, ScanFail=0. Else ScanFail=1, BestSetting/BestRunLen unchanged, outputs return to RestoreSetting. Pulse ScanDone; go to IDLE.
- Runs are linear over 0..31; no wrap-around between setting 31 and setting 0.
- ScanStart outside IDLE is ignored. ManualEn/ManualSetting ignored while ScanBusy.

## Timing
- Reset values: SelClkPhase=0, ClkFineDelay=0, ScanBusy=0, ScanDone=0, ScanFail=0, BestSetting=0, BestRunLen=0, state IDLE.
- Rst mid-scan: all state and outputs return to reset values on the next edge; no ScanDone pulse.
- ScanStart accepted at edge t: ScanBusy=1 and setting 0 driven from t+1.
- Each setting occupies SETTLE_CYCLES+DWELL_CYCLES+1 cycles; the new setting is driven in the first SETTLE cycle.
- ScanDone pulses 32*(SETTLE_CYCLES+DWELL_CYCLES+1)+1 cycles after acceptance, coincident with ScanBusy falling and the final outputs appearing.
- IDLE output follows ManualEn/ManualSetting with one-cycle register latency.

## Test plan
- Bench params SETTLE=2, DWELL=8, MIN_HITS=2. SyncHit continuous at all settings -> BestSetting=15, BestRunLen=32, ScanDone after 32*11+1=353 cycles, ScanFail=0.
- Hits only at settings 10..20 -> BestSetting=15 (SelClkPhase=0, ClkFineDelay=15), BestRunLen=11.
- Good runs 3..6 and 20..23 (equal length) -> BestSetting=4, BestRunLen=4; add run 25..31 -> BestSetting=28, BestRunLen=7 (run closed at s=31).
- Exactly 1 hit per setting, or hits only during SETTLE -> ScanFail=1, outputs restored to pre-scan setting, BestSetting unchanged.
- Rst asserted mid-DWELL at setting 12 -> outputs 0, ScanBusy=0, no ScanDone; a second ScanStart mid-scan is ignored (done timing unchanged).
- IDLE with ManualEn=1, ManualSetting=5'b10011 -> SelClkPhase=1, ClkFineDelay=3 one cycle later; ManualEn=0 -> BestSetting driven.
